trap_controller: RTL and testbench
==================================

Name: trap_controller

Overview:
- Sequences machine-mode trap entry and `mret` return around the CSR file and the core's program counter.
- Arbitrates between synchronous exceptions and the three machine interrupt sources (external, software, timer).
- Latches the winning cause and drives the CSR-side trap capture and the `mstatus` MIE/MPIE updates.
- Issues a stall and a single-cycle PC redirect to the trap vector or to `mepc`.

Parameters:
VECTORED, 0, 1 = interrupts redirect to `base + 4*code`; 0 = all traps redirect to `base`.
CODE_WIDTH, 31, width of the exception code field; matches `mcause` minus the interrupt bit.

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
instruction_boundary  in  1  core is between instructions; interrupts may be taken
program_counter  in  32  PC of the faulting instruction (exceptions) or the next instruction (interrupts)
exception_valid  in  1  synchronous exception this cycle
exception_cause  in  CODE_WIDTH  exception code accompanying exception_valid
mret  in  1  `mret` is executing this cycle
irq_pending  in  3  {meip, mtip, msip}
irq_enable  in  3  {meie, mtie, msie}
mstatus_mie  in  1  current global machine interrupt enable
mstatus_mpie  in  1  current previous-MIE bit
mtvec_base  in  30  `mtvec[31:2]`
mepc  in  30  `mepc[31:2]`
trap  out  1  one-cycle pulse; CSR file captures `mcause` and `mepc`
interrupt  out  1  `mcause` interrupt bit for this trap
exception_code  out  CODE_WIDTH  `mcause` code for this trap
trap_pc  out  32  value to store in `mepc`
mstatus_write  out  1  one-cycle strobe to update MIE and MPIE
mstatus_mie_next  out  1  new MIE
mstatus_mpie_next  out  1  new MPIE
redirect  out  1  one-cycle PC redirect strobe
redirect_pc  out  32  redirect target, bits [1:0] always 0
stall  out  1  core must hold; high in every non-IDLE state

Behaviour:
- **Reset:** on reset_n low, go to IDLE immediately (asynchronously). All outputs, latched cause and latched PC are 0. Reset mid-sequence abandons it with no `trap` or `redirect` pulse.
- **States:** IDLE, ENTER, RETURN, REDIRECT. All outputs are registered, decoded from state plus latched registers.
- **Eligible interrupt:** `irq_pending & irq_enable != 0`, `mstatus_mie == 1` and `instruction_boundary == 1`, all sampled in IDLE only.
- **Priority in IDLE:**
  - `exception_valid` wins over `mret`, and `mret` wins over an eligible interrupt.
  - Among interrupts: MEI (code 11) > MSI (code 3) > MTI (code 7).
- **IDLE → ENTER** on an exception or an eligible interrupt.
  - Latch `interrupt` (0 or 1) and the code.
  - Latch `trap_pc = program_counter` with bits [1:0] forced to 0.
  - Compute the target: `{mtvec_base, 2'b0}`, plus `4*code` when VECTORED=1 and interrupt=1. Addition is 32-bit and wraps modulo 2^32.
- **ENTER (1 cycle):**
  - `trap = 1`.
  - `mstatus_write = 1`, with `mstatus_mpie_next = mstatus_mie` as sampled at detection and `mstatus_mie_next = 0`.
  - Next state is REDIRECT.
- **IDLE → RETURN** on `mret` without an exception. Latch target `{mepc, 2'b0}`.
- **RETURN (1 cycle):** `mstatus_write = 1`, `mstatus_mie_next = mstatus_mpie`, `mstatus_mpie_next = 1`. Next state is REDIRECT.
- **REDIRECT (1 cycle):** `redirect = 1`, `redirect_pc = latched target`. Next state is IDLE.
- **Latency:** event in cycle N → `trap`/`mstatus_write` high in N+1 → `redirect` high in N+2 → IDLE in N+3. A new event is accepted in N+3.
- **Sampling rules:**
  - Inputs other than `mstatus_mie`/`mstatus_mpie` are ignored outside IDLE. A pending change during a sequence does not alter the latched cause.
  - An exception arriving outside IDLE is dropped; the bench flags it as a core protocol error.
- **Pulse isolation:** `trap`, `mstatus_write` and `redirect` are never high in the same cycle, and each is high for exactly one cycle per sequence.
- **Interrupt re-entry:** after ENTER, MIE is 0, so an interrupt still pending does not retrigger until software re-enables MIE or executes `mret`.

Test Plan:
- **Exception entry:** `exception_valid=1`, cause=2, PC=0x0000_0104, base=0x0000_0040 (mtvec=0x100), MIE=1 → N+1: `trap=1`, `interrupt=0`, code=2, `trap_pc=0x104`, `mie_next=0`, `mpie_next=1`; N+2: `redirect=1`, `redirect_pc=0x100`; `stall` high N+1..N+2.
- **Interrupt priority, vectored:** VECTORED=1, `pending=3'b111`, `enable=3'b111`, MIE=1, boundary=1, mtvec=0x100 → code=11, `interrupt=1`, `redirect_pc=0x12C`. Repeat with `pending=3'b011` → code=3, `redirect_pc=0x10C`.
- **Interrupt gating:** `pending=3'b100`, `enable=3'b100`, with MIE=0 or boundary=0 → no `trap` or `stall` for 20 cycles. Set MIE=1 and boundary=1 → trap with code 11.
- **Return:** `mret=1`, `mepc[31:2]=0x41` (0x104), MPIE=1 → N+1: `mstatus_write=1`, `mie_next=1`, `mpie_next=1`; N+2: `redirect_pc=0x104`.
- **Simultaneous events:** `exception_valid=1` (cause 11), `mret=1` and an eligible MTI in the same cycle → exception sequence with code 11 and `interrupt=0`; no RETURN state.
- **Reset mid-sequence:** assert reset_n low during ENTER → all outputs 0 within the same cycle, no `redirect`. Release, then raise an exception → normal N+1/N+2 timing.

Source files
------------

// File: rtl/trap_controller_if.sv
// ---------------------------------------------------------------------------
// trap_controller_if
//
// Purpose:
//   Bundles the core-side and CSR-side signals of the machine-mode trap
//   controller. The clock and reset are not part of the bundle.
//
// Port summary (signal groups):
//   Core status  : instruction_boundary, program_counter, exception_valid,
//                  exception_cause, mret
//   Interrupts   : irq_pending {meip, mtip, msip}, irq_enable {meie, mtie, msie}
//   CSR state    : mstatus_mie, mstatus_mpie, mtvec_base (mtvec[31:2]),
//                  mepc (mepc[31:2])
//   Trap capture : trap, interrupt, exception_code, trap_pc
//   mstatus      : mstatus_write, mstatus_mie_next, mstatus_mpie_next
//   PC control   : redirect, redirect_pc, stall
//
// Modports:
//   slave  - the trap controller (consumes core/CSR state, drives results)
//   master - the core/CSR side (drives core/CSR state, observes results)
// ---------------------------------------------------------------------------
interface trap_controller_if #(
    parameter int CODE_WIDTH = 31
);
    logic                  instruction_boundary;
    logic [31:0]           program_counter;
    logic                  exception_valid;
    logic [CODE_WIDTH-1:0] exception_cause;
    logic                  mret;
    logic [2:0]            irq_pending;
    logic [2:0]            irq_enable;
    logic                  mstatus_mie;
    logic                  mstatus_mpie;
    logic [29:0]           mtvec_base;
    logic [29:0]           mepc;

    logic                  trap;
    logic                  interrupt;
    logic [CODE_WIDTH-1:0] exception_code;
    logic [31:0]           trap_pc;
    logic                  mstatus_write;
    logic                  mstatus_mie_next;
    logic                  mstatus_mpie_next;
    logic                  redirect;
    logic [31:0]           redirect_pc;
    logic                  stall;

    modport slave (
        input  instruction_boundary, program_counter, exception_valid,
               exception_cause, mret, irq_pending, irq_enable,
               mstatus_mie, mstatus_mpie, mtvec_base, mepc,
        output trap, interrupt, exception_code, trap_pc,
               mstatus_write, mstatus_mie_next, mstatus_mpie_next,
               redirect, redirect_pc, stall
    );

    modport master (
        output instruction_boundary, program_counter, exception_valid,
               exception_cause, mret, irq_pending, irq_enable,
               mstatus_mie, mstatus_mpie, mtvec_base, mepc,
        input  trap, interrupt, exception_code, trap_pc,
               mstatus_write, mstatus_mie_next, mstatus_mpie_next,
               redirect, redirect_pc, stall
    );
endinterface

// File: rtl/trap_controller.sv
// ---------------------------------------------------------------------------
// trap_controller
//
// Purpose:
//   Sequences machine-mode trap entry and mret return. In IDLE it arbitrates
//   between a synchronous exception, mret and the three machine interrupts,
//   then walks ENTER/RETURN -> REDIRECT -> IDLE, producing a one-cycle CSR
//   capture pulse, a one-cycle mstatus update strobe and a one-cycle PC
//   redirect, with stall held for the whole sequence.
//
// Parameters:
//   VECTORED   - 1: interrupts redirect to base + 4*code; 0: always base
//   CODE_WIDTH - width of the mcause code field
//
// Ports:
//   clock   - system clock, rising edge
//   reset_n - asynchronous active-low reset
//   bus     - trap_controller_if slave modport (see interface header)
// ---------------------------------------------------------------------------
module trap_controller #(
    parameter int VECTORED   = 0,
    parameter int CODE_WIDTH = 31
) (
    input logic              clock,
    input logic              reset_n,
    trap_controller_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ENTER,
        RETURN,
        REDIRECT
    } state_t;

    state_t                state;

    logic [2:0]            irq_active;
    logic                  irq_eligible;
    logic [CODE_WIDTH-1:0] irq_code;
    logic                  take_interrupt;
    logic [CODE_WIDTH-1:0] trap_code;
    logic [31:0]           base_addr;
    logic [31:0]           vector_offset;
    logic [31:0]           trap_target;

    // Decide what an IDLE-cycle trap would look like: which interrupt (if
    // any) wins, whether it beats the exception/mret, and where to jump.
    // Interrupt order is MEI > MSI > MTI, which is not the bit order of
    // irq_pending ({meip, mtip, msip}), hence the explicit selection.
    always_comb begin
        irq_active     = bus.irq_pending & bus.irq_enable;
        irq_eligible   = (irq_active != 3'b000) && bus.mstatus_mie
                         && bus.instruction_boundary;
        irq_code       = CODE_WIDTH'(7);
        if (irq_active[2]) begin
            irq_code = CODE_WIDTH'(11);
        end else if (irq_active[0]) begin
            irq_code = CODE_WIDTH'(3);
        end
        take_interrupt = !bus.exception_valid && !bus.mret && irq_eligible;
        trap_code      = take_interrupt ? irq_code : bus.exception_cause;
        base_addr      = {bus.mtvec_base, 2'b00};
        vector_offset  = 32'(trap_code) << 2;
        trap_target    = base_addr;
        if ((VECTORED != 0) && take_interrupt) begin
            trap_target = base_addr + vector_offset;
        end
    end

    // Sequencer with all outputs registered. Everything the later states
    // need (cause, PC, target, new mstatus bits) is captured on leaving IDLE,
    // so input changes during a sequence cannot disturb it. redirect_pc
    // doubles as the latched target register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                 <= IDLE;
            bus.trap              <= 1'b0;
            bus.interrupt         <= 1'b0;
            bus.exception_code    <= '0;
            bus.trap_pc           <= 32'h0;
            bus.mstatus_write     <= 1'b0;
            bus.mstatus_mie_next  <= 1'b0;
            bus.mstatus_mpie_next <= 1'b0;
            bus.redirect          <= 1'b0;
            bus.redirect_pc       <= 32'h0;
            bus.stall             <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.exception_valid || take_interrupt) begin
                        state                 <= ENTER;
                        bus.stall             <= 1'b1;
                        bus.trap              <= 1'b1;
                        bus.mstatus_write     <= 1'b1;
                        bus.mstatus_mie_next  <= 1'b0;
                        bus.mstatus_mpie_next <= bus.mstatus_mie;
                        bus.interrupt         <= take_interrupt;
                        bus.exception_code    <= trap_code;
                        bus.trap_pc           <= bus.program_counter & ~32'h3;
                        bus.redirect_pc       <= trap_target;
                    end else if (bus.mret) begin
                        state                 <= RETURN;
                        bus.stall             <= 1'b1;
                        bus.mstatus_write     <= 1'b1;
                        bus.mstatus_mie_next  <= bus.mstatus_mpie;
                        bus.mstatus_mpie_next <= 1'b1;
                        bus.redirect_pc       <= {bus.mepc, 2'b00};
                    end
                end
                ENTER, RETURN: begin
                    state             <= REDIRECT;
                    bus.trap          <= 1'b0;
                    bus.mstatus_write <= 1'b0;
                    bus.redirect      <= 1'b1;
                end
                REDIRECT: begin
                    state        <= IDLE;
                    bus.redirect <= 1'b0;
                    bus.stall    <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_controller.sv
// ---------------------------------------------------------------------------
// tb_trap_controller
//
// Purpose:
//   Directed self-checking bench for trap_controller (VECTORED=1). Inputs
//   change right after a falling edge; outputs are sampled on falling edges.
// ---------------------------------------------------------------------------
module tb_trap_controller;

    logic clock;
    logic reset_n;
    int   assertions;
    int   failures;

    trap_controller_if #(.CODE_WIDTH(31)) bus ();

    trap_controller #(
        .VECTORED  (1),
        .CODE_WIDTH(31)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    // Free-running 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Drive every core/CSR input at once.
    task automatic applyStimulus(
        input logic        exc_valid,
        input logic [30:0] exc_cause,
        input logic        mret_in,
        input logic [2:0]  pending,
        input logic [2:0]  enable,
        input logic        mie,
        input logic        mpie,
        input logic        boundary,
        input logic [31:0] pc,
        input logic [29:0] base,
        input logic [29:0] mepc_in
    );
        bus.exception_valid      = exc_valid;
        bus.exception_cause      = exc_cause;
        bus.mret                 = mret_in;
        bus.irq_pending          = pending;
        bus.irq_enable           = enable;
        bus.mstatus_mie          = mie;
        bus.mstatus_mpie         = mpie;
        bus.instruction_boundary = boundary;
        bus.program_counter      = pc;
        bus.mtvec_base           = base;
        bus.mepc                 = mepc_in;
    endtask

    // Quiet inputs with the default trap base of 0x100.
    task automatic applyIdle();
        applyStimulus(1'b0, 31'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1,
                      32'h0, 30'h40, 30'h0);
    endtask

    task automatic nextCycle();
        @(negedge clock);
    endtask

    // Single comparison point.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertions++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h",
                   tag, observed, expected);
        end
    endtask

    // No sequence in progress and no pulses.
    task automatic checkIdle(input string tag);
        checkOutput({tag, ".trap"},          32'(bus.trap),          32'h0);
        checkOutput({tag, ".mstatus_write"}, 32'(bus.mstatus_write), 32'h0);
        checkOutput({tag, ".redirect"},      32'(bus.redirect),      32'h0);
        checkOutput({tag, ".stall"},         32'(bus.stall),         32'h0);
    endtask

    // ENTER cycle: trap capture plus mstatus update, MIE always cleared.
    task automatic checkEnter(input string tag, input logic [31:0] irq,
                              input logic [31:0] code, input logic [31:0] pc,
                              input logic [31:0] mpie_next);
        checkOutput({tag, ".trap"},          32'(bus.trap),              32'h1);
        checkOutput({tag, ".interrupt"},     32'(bus.interrupt),         irq);
        checkOutput({tag, ".code"},          32'(bus.exception_code),    code);
        checkOutput({tag, ".trap_pc"},       bus.trap_pc,                pc);
        checkOutput({tag, ".mstatus_write"}, 32'(bus.mstatus_write),     32'h1);
        checkOutput({tag, ".mie_next"},      32'(bus.mstatus_mie_next),  32'h0);
        checkOutput({tag, ".mpie_next"},     32'(bus.mstatus_mpie_next), mpie_next);
        checkOutput({tag, ".redirect"},      32'(bus.redirect),          32'h0);
        checkOutput({tag, ".stall"},         32'(bus.stall),             32'h1);
    endtask

    // REDIRECT cycle: only the redirect pulse, still stalled.
    task automatic checkRedirect(input string tag, input logic [31:0] pc);
        checkOutput({tag, ".redirect"},      32'(bus.redirect),      32'h1);
        checkOutput({tag, ".redirect_pc"},   bus.redirect_pc,        pc);
        checkOutput({tag, ".trap"},          32'(bus.trap),          32'h0);
        checkOutput({tag, ".mstatus_write"}, 32'(bus.mstatus_write), 32'h0);
        checkOutput({tag, ".stall"},         32'(bus.stall),         32'h1);
    endtask

    initial begin
        assertions = 0;
        failures   = 0;

        // Reset state
        $display("[TB] reset");
        reset_n = 1'b0;
        applyIdle();
        repeat (3) nextCycle();
        checkOutput("rst.trap",        32'(bus.trap),           32'h0);
        checkOutput("rst.stall",       32'(bus.stall),          32'h0);
        checkOutput("rst.redirect",    32'(bus.redirect),       32'h0);
        checkOutput("rst.code",        32'(bus.exception_code), 32'h0);
        checkOutput("rst.trap_pc",     bus.trap_pc,             32'h0);
        checkOutput("rst.redirect_pc", bus.redirect_pc,         32'h0);
        reset_n = 1'b1;
        nextCycle();
        checkIdle("rst_release");

        // Exception entry; a second exception during the sequence is dropped
        $display("[TB] exception entry");
        applyStimulus(1'b1, 31'd2, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1,
                      32'h0000_0104, 30'h40, 30'h0);
        nextCycle();
        checkEnter("exc", 32'h0, 32'd2, 32'h0000_0104, 32'h1);
        applyStimulus(1'b1, 31'd5, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1,
                      32'h0000_0500, 30'h40, 30'h0);
        nextCycle();
        checkRedirect("exc", 32'h0000_0100);
        checkOutput("exc.code_held", 32'(bus.exception_code), 32'd2);
        applyIdle();
        nextCycle();
        checkIdle("exc_done");

        // Vectored MEI with all sources pending; unaligned PC; no re-entry
        $display("[TB] interrupt priority");
        applyStimulus(1'b0, 31'd0, 1'b0, 3'b111, 3'b111, 1'b1, 1'b0, 1'b1,
                      32'h0000_0307, 30'h40, 30'h0);
        nextCycle();
        checkEnter("mei", 32'h1, 32'd11, 32'h0000_0304, 32'h1);
        applyStimulus(1'b0, 31'd0, 1'b0, 3'b011, 3'b111, 1'b1, 1'b0, 1'b1,
                      32'h0000_0307, 30'h40, 30'h0);
        nextCycle();
        checkRedirect("mei", 32'h0000_012C);
        checkOutput("mei.code_held", 32'(bus.exception_code), 32'd11);
        applyStimulus(1'b0, 31'd0, 1'b0, 3'b111, 3'b111, 1'b0, 1'b1, 1'b1,
                      32'h0000_0400, 30'h40, 30'h0);
        nextCycle();
        checkIdle("mei_done");
        nextCycle();
        checkIdle("mei_no_reentry");

        // MSI beats MTI
        applyStimulus(1'b0, 31'd0, 1'b0, 3'b011, 3'b111, 1'b1, 1'b0, 1'b1,
                      32'h0000_0108, 30'h40, 30'h0);
        nextCycle();
        checkEnter("msi", 32'h1, 32'd3, 32'h0000_0108, 32'h1);
        applyIdle();
        nextCycle();
        checkRedirect("msi", 32'h0000_010C);
        nextCycle();
        checkIdle("msi_done");

        // MTI alone
        applyStimulus(1'b0, 31'd0, 1'b0, 3'b010, 3'b111, 1'b1, 1'b0, 1'b1,
                      32'h0000_0208, 30'h40, 30'h0);
        nextCycle();
        checkEnter("mti", 32'h1, 32'd7, 32'h0000_0208, 32'h1);
        applyIdle();
        nextCycle();
        checkRedirect("mti", 32'h0000_011C);
        nextCycle();
        checkIdle("mti_done");

        // Vector address wraps modulo 2^32: 0xFFFFFFFC + 44 = 0x28
        applyStimulus(1'b0, 31'd0, 1'b0, 3'b100, 3'b100, 1'b1, 1'b0, 1'b1,
                      32'h0000_0010, 30'h3FFF_FFFF, 30'h0);
        nextCycle();
        checkEnter("wrap", 32'h1, 32'd11, 32'h0000_0010, 32'h1);
        applyIdle();
        nextCycle();
        checkRedirect("wrap", 32'h0000_0028);
        nextCycle();
        checkIdle("wrap_done");

        // Interrupt gating by MIE, instruction boundary and enable
        $display("[TB] interrupt gating");
        applyStimulus(1'b0, 31'd0, 1'b0, 3'b100, 3'b100, 1'b0, 1'b0, 1'b1,
                      32'h0000_0300, 30'h40, 30'h0);
        for (int i = 0; i < 20; i++) begin
            nextCycle();
            checkIdle("gate_mie0");
        end
        applyStimulus(1'b0, 31'd0, 1'b0, 3'b100, 3'b100, 1'b1, 1'b0, 1'b0,
                      32'h0000_0300, 30'h40, 30'h0);
        for (int i = 0; i < 20; i++) begin
            nextCycle();
            checkIdle("gate_boundary0");
        end
        applyStimulus(1'b0, 31'd0, 1'b0, 3'b100, 3'b011, 1'b1, 1'b0, 1'b1,
                      32'h0000_0300, 30'h40, 30'h0);
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            checkIdle("gate_enable");
        end
        applyStimulus(1'b0, 31'd0, 1'b0, 3'b100, 3'b100, 1'b1, 1'b0, 1'b1,
                      32'h0000_0300, 30'h40, 30'h0);
        nextCycle();
        checkEnter("gate_open", 32'h1, 32'd11, 32'h0000_0300, 32'h1);
        applyIdle();
        nextCycle();
        checkRedirect("gate_open", 32'h0000_012C);
        nextCycle();
        checkIdle("gate_done");

        // mret with MPIE=1
        $display("[TB] return");
        applyStimulus(1'b0, 31'd0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1,
                      32'h0000_0000, 30'h40, 30'h41);
        nextCycle();
        checkOutput("ret.mstatus_write", 32'(bus.mstatus_write),     32'h1);
        checkOutput("ret.mie_next",      32'(bus.mstatus_mie_next),  32'h1);
        checkOutput("ret.mpie_next",     32'(bus.mstatus_mpie_next), 32'h1);
        checkOutput("ret.trap",          32'(bus.trap),              32'h0);
        checkOutput("ret.redirect",      32'(bus.redirect),          32'h0);
        checkOutput("ret.stall",         32'(bus.stall),             32'h1);
        applyIdle();
        nextCycle();
        checkRedirect("ret", 32'h0000_0104);
        nextCycle();
        checkIdle("ret_done");

        // mret with MPIE=0 to the top of the address space
        applyStimulus(1'b0, 31'd0, 1'b1, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1,
                      32'h0000_0000, 30'h40, 30'h3FFF_FFFF);
        nextCycle();
        checkOutput("ret2.mstatus_write", 32'(bus.mstatus_write),     32'h1);
        checkOutput("ret2.mie_next",      32'(bus.mstatus_mie_next),  32'h0);
        checkOutput("ret2.mpie_next",     32'(bus.mstatus_mpie_next), 32'h1);
        applyIdle();
        nextCycle();
        checkRedirect("ret2", 32'hFFFF_FFFC);
        nextCycle();
        checkIdle("ret2_done");

        // Exception, mret and eligible MTI together: exception wins
        $display("[TB] simultaneous events");
        applyStimulus(1'b1, 31'd11, 1'b1, 3'b010, 3'b010, 1'b1, 1'b1, 1'b1,
                      32'h0000_0200, 30'h40, 30'h41);
        nextCycle();
        checkEnter("simul", 32'h0, 32'd11, 32'h0000_0200, 32'h1);
        applyIdle();
        nextCycle();
        checkRedirect("simul", 32'h0000_0100);
        nextCycle();
        checkIdle("simul_done");

        // Reset during ENTER abandons the sequence
        $display("[TB] reset mid-sequence");
        applyStimulus(1'b1, 31'd2, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1,
                      32'h0000_0104, 30'h40, 30'h0);
        nextCycle();
        checkOutput("mid.trap_before", 32'(bus.trap), 32'h1);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("mid.trap",          32'(bus.trap),          32'h0);
        checkOutput("mid.stall",         32'(bus.stall),         32'h0);
        checkOutput("mid.mstatus_write", 32'(bus.mstatus_write), 32'h0);
        checkOutput("mid.interrupt",     32'(bus.interrupt),     32'h0);
        checkOutput("mid.code",          32'(bus.exception_code), 32'h0);
        checkOutput("mid.trap_pc",       bus.trap_pc,            32'h0);
        checkOutput("mid.redirect_pc",   bus.redirect_pc,        32'h0);
        applyIdle();
        nextCycle();
        checkOutput("mid.no_redirect", 32'(bus.redirect), 32'h0);
        reset_n = 1'b1;
        nextCycle();
        checkIdle("mid_release");
        applyStimulus(1'b1, 31'd4, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1,
                      32'h0000_0080, 30'h40, 30'h0);
        nextCycle();
        checkEnter("post_rst", 32'h0, 32'd4, 32'h0000_0080, 32'h0);
        applyIdle();
        nextCycle();
        checkRedirect("post_rst", 32'h0000_0100);
        nextCycle();
        checkIdle("post_rst_done");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertions, failures);
        $finish;
    end

endmodule
